pipe_skid_stage: RTL
====================

Name: pipe_skid_stage

Overview:
Parametrised elastic pipeline register, the successor to the fixed 3×8-bit IF/ID latch. Carries a packed payload of WIDTH bits using a valid/ready handshake with a 2-entry skid buffer, so backpressure never forms a combinational ready path. It keeps stage-level stall and flush (flush loads NOP_VALUE) and adds occupancy and flush-drop reporting. It is instantiated between any two pipeline stages (IF/ID, ID/EX, …).

Parameters:
WIDTH, 24, payload width in bits (default = {instruction[7:0], pc[7:0], pc_plus_1[7:0]})
NOP_VALUE, 0, payload value loaded on reset/flush and presented whenever out_valid=0
DROP_CNT_W, 8, width of saturating flush-drop counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept (registered; = !skid_valid)
in_data  in  WIDTH  upstream payload
out_valid  out  1  downstream payload valid
out_ready  in  1  downstream accepts
out_data  out  WIDTH  payload to next stage (NOP_VALUE when !out_valid)
stall  in  1  freeze output side: no dequeue this cycle
flush  in  1  discard all held and incoming entries
occupancy  out  2  entries held: 0, 1 or 2
drop_count  out  DROP_CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Storage: main {m_valid, m_data} drives out_*; skid {s_valid, s_data}. s_valid=1 implies m_valid=1.
- in_fire = in_valid & in_ready & !flush; out_fire = m_valid & out_ready & !stall.
- out_valid = m_valid; out_data = m_valid ? m_data : NOP_VALUE; in_ready = !s_valid (flop output only, no path from out_ready).
- occupancy = m_valid + s_valid, registered-equivalent (derived from flops only).
- Reset (async, rst_n=0): m_valid=s_valid=0, m_data=s_data=NOP_VALUE, in_ready=1, out_valid=0, occupancy=0, drop_count=0. Deassertion takes effect at the next rising edge.
- Latency: 1 cycle, accept at edge N → out_valid at N+1. Throughput: 1 per cycle when out_ready=1.
- Transitions (no flush):
  - empty + in_fire → main<=in.
  - main only + in_fire & out_fire → main<=in.
  - main only + out_fire only → empty.
  - main only + in_fire only → skid<=in (in_ready drops next cycle).
  - full + out_fire → main<=skid, skid cleared (in_ready=1 next cycle).
  - full + no out_fire → hold.
- FIFO order always preserved; no duplication, no loss except by flush.
- stall=1 with out_ready=1: no dequeue; upstream may still fill the skid until full.
- flush=1 (priority over all): next edge m_valid=s_valid=0, both data regs=NOP_VALUE, incoming beat dropped even if in_valid=1. drop_count += m_valid+s_valid+(in_valid&in_ready), saturating at all-ones. A same-cycle out_fire is still reported to downstream but is counted as dropped.
- flush and stall both high: flush wins.
- Reset mid-transfer: all state cleared immediately, drop_count not incremented.

Decomposition:
- Shared package pipe_pkg: default payload layout constants (INSTR_W=8, PC_W=8, field offsets), NOP_INSTR=8'h00, occupancy encodings OCC_EMPTY/OCC_ONE/OCC_FULL.
- One sub-module, pipe_entry_reg: a valid+data register with load, clear-to-NOP_VALUE and async reset, instantiated twice (main, skid). Control logic stays in the top.

Test Plan:
- Reset: rst_n=0 mid-cycle → out_valid=0, out_data=0, in_ready=1, occupancy=0, drop_count=0 without waiting for a clock edge.
- Flow-through: in_data=24'hAA1011, then 24'hBB1112, out_ready=1 → out_data=AA1011 one cycle after accept, BB1112 the next; occupancy stays 1.
- Backpressure: out_ready=0, send AA1011, BB1112, CC1213 → first two accepted, in_ready=0, occupancy=2, CC1213 held upstream. Then out_ready=1 → outputs AA, BB, CC in order with no gaps.
- Stall: full stage, out_ready=1, stall=1 for 3 cycles → out_data stays AA1011, occupancy=2. After release, drains in order.
- Flush: occupancy=2 with in_valid=1 and in_ready=0, flush=1 → next cycle out_valid=0, out_data=0, occupancy=0, drop_count=2. Flush with empty stage and in_valid=1 → drop_count=3.
- Saturation: DROP_CNT_W=2, four flushes of a full stage → drop_count=3 and holds there.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the elastic pipeline register family.
//   - Default payload layout {instruction, pc, pc_plus_1}: field widths and
//     bit offsets, plus a helper that packs the three fields.
//   - NOP instruction encoding.
//   - Occupancy encodings reported by pipe_skid_stage.
//   - Entry indices for the main and skid registers.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int INSTR_W   = 8;
    localparam int PC_W      = 8;
    localparam int PC1_W     = 8;

    // Bit offsets inside the packed default payload (pc_plus_1 in the LSBs).
    localparam int PC1_LSB   = 0;
    localparam int PC_LSB    = PC1_LSB + PC1_W;
    localparam int INSTR_LSB = PC_LSB + PC_W;
    localparam int PAYLOAD_W = INSTR_LSB + INSTR_W;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 8'h00;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Storage slots: main drives the output, skid absorbs one extra beat.
    localparam int ENTRY_MAIN  = 0;
    localparam int ENTRY_SKID  = 1;
    localparam int NUM_ENTRIES = 2;

    function automatic logic [PAYLOAD_W-1:0] pack_payload(
        input logic [INSTR_W-1:0] instr,
        input logic [PC_W-1:0]    pc,
        input logic [PC1_W-1:0]   pc_plus_1
    );
        return {instr, pc, pc_plus_1};
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
// One valid+data storage slot of the skid stage.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (valid=0, data=NOP_VALUE)
//   load       capture load_data and mark the slot valid
//   clear      empty the slot and return data to NOP_VALUE (wins over load)
//   load_data  payload captured on load
//   valid      slot holds a payload
//   data       held payload
// -----------------------------------------------------------------------------
import pipe_pkg::*;

module pipe_entry_reg #(
    parameter int               WIDTH     = PAYLOAD_W,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= NOP_VALUE;
        end else if (clear) begin
            valid_reg <= 1'b0;
            data_reg  <= NOP_VALUE;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= load_data;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// pipe_skid_stage
// Elastic pipeline register with a 2-entry skid buffer. in_ready comes straight
// from a flop, so downstream backpressure never reaches upstream
// combinationally.
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     upstream beat valid
//   in_ready     stage can accept (= skid slot empty)
//   in_data      upstream payload
//   out_valid    main slot holds a beat
//   out_ready    downstream accepts
//   out_data     main payload, NOP_VALUE when out_valid=0
//   stall        block dequeue this cycle (upstream may still fill)
//   flush        discard held and incoming beats (priority over everything)
//   occupancy    number of held beats (0..2)
//   drop_count   saturating count of valid beats discarded by flush
// -----------------------------------------------------------------------------
import pipe_pkg::*;

module pipe_skid_stage #(
    parameter int               WIDTH      = PAYLOAD_W,
    parameter logic [WIDTH-1:0] NOP_VALUE  = '0,
    parameter int               DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic [1:0]            occupancy,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    logic [NUM_ENTRIES-1:0] entry_load;
    logic [NUM_ENTRIES-1:0] entry_clear;
    logic [NUM_ENTRIES-1:0] entry_valid;
    logic [WIDTH-1:0]       entry_din  [NUM_ENTRIES];
    logic [WIDTH-1:0]       entry_data [NUM_ENTRIES];

    logic m_valid;
    logic s_valid;
    logic in_fire;
    logic out_fire;
    occ_t occ_state;

    logic [DROP_CNT_W-1:0] drop_count_reg;
    logic [DROP_CNT_W-1:0] drop_count_next;
    logic [1:0]            drop_inc;
    logic [DROP_CNT_W+1:0] drop_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
            pipe_entry_reg #(
                .WIDTH     (WIDTH),
                .NOP_VALUE (NOP_VALUE)
            ) u_entry (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (entry_load[gi]),
                .clear     (entry_clear[gi]),
                .load_data (entry_din[gi]),
                .valid     (entry_valid[gi]),
                .data      (entry_data[gi])
            );
        end
    endgenerate

    assign m_valid  = entry_valid[ENTRY_MAIN];
    assign s_valid  = entry_valid[ENTRY_SKID];

    assign in_ready = !s_valid;
    assign in_fire  = in_valid & in_ready & !flush;
    assign out_fire = m_valid & out_ready & !stall;

    assign out_valid = m_valid;
    assign out_data  = m_valid ? entry_data[ENTRY_MAIN] : NOP_VALUE;

    // The skid slot only ever captures the upstream payload.
    assign entry_din[ENTRY_SKID] = in_data;

    always_comb begin
        entry_load             = '0;
        entry_clear            = '0;
        entry_din[ENTRY_MAIN]  = in_data;

        if (flush) begin
            entry_clear = '1;
        end else if (s_valid) begin
            // Full: in_ready is low, so only a dequeue can change state.
            if (out_fire) begin
                entry_load[ENTRY_MAIN]  = 1'b1;
                entry_din[ENTRY_MAIN]   = entry_data[ENTRY_SKID];
                entry_clear[ENTRY_SKID] = 1'b1;
            end
        end else if (m_valid) begin
            if (out_fire && in_fire) begin
                entry_load[ENTRY_MAIN] = 1'b1;
            end else if (out_fire) begin
                entry_clear[ENTRY_MAIN] = 1'b1;
            end else if (in_fire) begin
                entry_load[ENTRY_SKID] = 1'b1;
            end
        end else if (in_fire) begin
            entry_load[ENTRY_MAIN] = 1'b1;
        end
    end

    // Occupancy decoded from flops only; skid valid implies main valid.
    always_comb begin
        occ_state = OCC_EMPTY;
        if (s_valid) begin
            occ_state = OCC_FULL;
        end else if (m_valid) begin
            occ_state = OCC_ONE;
        end
    end

    assign occupancy = occ_state;

    // A flush discards every held beat plus the beat upstream is offering
    // this cycle (a beat leaving downstream in the same cycle still counts).
    always_comb begin
        drop_inc = {1'b0, m_valid} + {1'b0, s_valid} + {1'b0, in_valid & in_ready};
        drop_sum = {2'b00, drop_count_reg} + {{DROP_CNT_W{1'b0}}, drop_inc};
        if (drop_sum > {2'b00, DROP_MAX}) begin
            drop_count_next = DROP_MAX;
        end else begin
            drop_count_next = drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count_reg <= '0;
        end else if (flush) begin
            drop_count_reg <= drop_count_next;
        end
    end

    assign drop_count = drop_count_reg;

endmodule
